// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and default region map for the ROM download router.
package jtframe_dwnld_pkg;

  // One queued SDRAM byte write, already decoded to bank, word address and lane.
  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Address region a download byte falls into; bank regions map 1:1 to bank numbers.
  typedef enum logic [2:0] {
    REG_BA0  = 3'd0,
    REG_BA1  = 3'd1,
    REG_BA2  = 3'd2,
    REG_BA3  = 3'd3,
    REG_PROM = 3'd4
  } region_t;

  // SDRAM write handshake states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wr_state_t;

  localparam logic [24:0] DEF_BA1_START  = 25'h10_0000;
  localparam logic [24:0] DEF_BA2_START  = 25'h20_0000;
  localparam logic [24:0] DEF_BA3_START  = 25'h30_0000;
  localparam logic [24:0] DEF_PROM_START = 25'h40_0000;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Single-clock FIFO holding decoded SDRAM writes between the ioctl stream and the SDRAM controller.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int FIFO_AW = 3
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Entry storage.
  // NOTE: the array is deliberately not reset; level alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dwnld_router.sv
// Routes the byte-wide ROM download into masked 16-bit SDRAM writes per bank region,
// diverting bytes above PROM_START to a PROM strobe port.
module jtframe_dwnld_router
  import jtframe_dwnld_pkg::*;
#(
  parameter int          NBANKS     = 4,
  parameter logic [24:0] BA1_START  = DEF_BA1_START,
  parameter logic [24:0] BA2_START  = DEF_BA2_START,
  parameter logic [24:0] BA3_START  = DEF_BA3_START,
  parameter logic [24:0] PROM_START = DEF_PROM_START,
  parameter int          FIFO_AW    = 3,
  parameter int          SWAB       = 0
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic [24:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        dwnld_busy,
  output logic        overflow
);

  region_t            region;
  logic [24:0]        region_start;
  logic [24:0]        offset;
  logic               byte_wr;
  logic               prom_hit;
  logic               sdram_push;
  fifo_entry_t        push_entry;
  fifo_entry_t        head;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [FIFO_AW:0]   fifo_level;
  wr_state_t          state;
  wr_state_t          next_state;
  logic               downloading_q;
  logic               download_rise;

  // Region decode: the highest enabled region start not above the byte address wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    region       = REG_BA0;
    region_start = '0;
    if (ioctl_addr >= PROM_START) begin
      region       = REG_PROM;
      region_start = PROM_START;
    end else if (NBANKS > 3 && ioctl_addr >= BA3_START) begin
      region       = REG_BA3;
      region_start = BA3_START;
    end else if (NBANKS > 2 && ioctl_addr >= BA2_START) begin
      region       = REG_BA2;
      region_start = BA2_START;
    end else if (NBANKS > 1 && ioctl_addr >= BA1_START) begin
      region       = REG_BA1;
      region_start = BA1_START;
    end
  end

  assign offset        = ioctl_addr - region_start;
  assign byte_wr       = ioctl_wr && downloading;
  assign prom_hit      = byte_wr && (region == REG_PROM);
  assign sdram_push    = byte_wr && (region != REG_PROM);
  assign download_rise = downloading && !downloading_q;

  // Pack the SDRAM entry; offset bit 0 picks the lane and SWAB flips the lane order.
  always_comb begin
    push_entry.bank = 2'(region);
    push_entry.addr = offset[22:1];
    push_entry.data = ioctl_data;
    push_entry.mask = (offset[0] ^ (SWAB != 0)) ? 2'b01 : 2'b10;
  end

  jtframe_dwnld_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sdram_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head = head_bits;

  // PROM bytes bypass the FIFO and strobe one cycle after the ioctl write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prom_we   <= 1'b0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= prom_hit;
      if (prom_hit) begin
        prom_addr <= offset;
        prom_data <= ioctl_data;
      end
    end
  end

  // Write state register; reset drops prog_we immediately through the output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state: stay in WAIT while another entry remains after the accepted one.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (!fifo_empty) next_state = ST_WAIT;
      ST_WAIT: if (prog_rdy && fifo_level == (FIFO_AW+1)'(1) && !sdram_push)
                 next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs: present the FIFO head while waiting and pop it on acceptance.
  always_comb begin
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_mask = '0;
    prog_bank = '0;
    fifo_pop  = 1'b0;
    if (state == ST_WAIT) begin
      prog_we   = 1'b1;
      prog_addr = head.addr;
      prog_data = {2{head.data}};
      prog_mask = head.mask;
      prog_bank = head.bank;
      fifo_pop  = prog_rdy;
    end
  end

  // Busy spans the download plus the drain; overflow is sticky per download.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      downloading_q <= 1'b0;
      dwnld_busy    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      downloading_q <= downloading;
      if (download_rise)
        dwnld_busy <= 1'b1;
      else if (!downloading && next_state == ST_IDLE)
        dwnld_busy <= 1'b0;
      if (sdram_push && fifo_full && !fifo_pop)
        overflow <= 1'b1;
      else if (download_rise)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_router.sv
// Self-checking bench for jtframe_dwnld_router with default parameters.
module tb_jtframe_dwnld_router;

  localparam int unsigned BA1  = 32'h10_0000;
  localparam int unsigned BA2  = 32'h20_0000;
  localparam int unsigned BA3  = 32'h30_0000;
  localparam int unsigned PROM = 32'h40_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_rdy = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prom_we;
  logic [24:0] prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;   // 0: driven by the test, 1: random, 2: one cycle after prog_we
  int wait_cnt = 0;
  int we_cycles = 0;

  // Records are {bank, addr, data16, mask} and {prom_addr, prom_data}.
  logic [41:0] got_q[$];
  logic [41:0] exp_q[$];
  logic [32:0] prom_got_q[$];
  logic [32:0] prom_exp_q[$];

  jtframe_dwnld_router dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_bank   (prog_bank),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SDRAM controller model and output monitor.
  always @(negedge clk) begin
    if (rdy_mode == 1) begin
      prog_rdy = ($urandom_range(0, 1) == 1);
    end else if (rdy_mode == 2) begin
      if (prog_we) begin
        wait_cnt = wait_cnt + 1;
        prog_rdy = (wait_cnt == 2);
        if (wait_cnt == 2) wait_cnt = 0;
      end else begin
        wait_cnt = 0;
        prog_rdy = 1'b0;
      end
    end
    #1;
    if (prog_we) we_cycles = we_cycles + 1;
    if (prog_we && prog_rdy) got_q.push_back({prog_bank, prog_addr, prog_data, prog_mask});
    if (prom_we) prom_got_q.push_back({prom_addr, prom_data});
  end

  // Reference: region by address thresholds, offset halves into a word, parity picks the lane.
  function automatic logic [41:0] model_sdram(input logic [24:0] a, input logic [7:0] d);
    int unsigned ai, start, off;
    logic [1:0]  bank;
    ai = 32'(a);
    if (ai >= BA3)      begin bank = 2'd3; start = BA3; end
    else if (ai >= BA2) begin bank = 2'd2; start = BA2; end
    else if (ai >= BA1) begin bank = 2'd1; start = BA1; end
    else                begin bank = 2'd0; start = 0;   end
    off = ai - start;
    return {bank, 22'(off / 2), d, d, ((off % 2) == 1) ? 2'b01 : 2'b10};
  endfunction

  function automatic logic [32:0] model_prom(input logic [24:0] a, input logic [7:0] d);
    int unsigned off;
    off = 32'(a) - PROM;
    return {25'(off), d};
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (downloading) begin
      if (32'(a) >= PROM) prom_exp_q.push_back(model_prom(a, d));
      else                exp_q.push_back(model_sdram(a, d));
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_download();
    @(negedge clk);
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    prom_got_q.delete();
    prom_exp_q.delete();
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      @(negedge clk);
    end
    if (got_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({prog_we, prog_bank, prog_addr, prog_data, prog_mask} !== '0) begin
      n_fail++;
      $display("FAIL reset_prog: got %h expected 0", {prog_we, prog_bank, prog_addr, prog_data, prog_mask});
    end
    n_tests++;
    if ({prom_we, prom_addr, prom_data, dwnld_busy, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_prom_flags: got %h expected 0", {prom_we, prom_addr, prom_data, dwnld_busy, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({prog_we, dwnld_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 00", {prog_we, dwnld_busy});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_queues();
    rdy_mode = 2;
    start_download();
    n_tests++;
    if (dwnld_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: got %b expected 1", dwnld_busy);
    end
    @(negedge clk);
    ioctl_addr = 25'h0; ioctl_data = 8'h11; ioctl_wr = 1'b1;
    exp_q.push_back(model_sdram(25'h0, 8'h11));
    @(negedge clk);
    ioctl_wr = 1'b0;
    n_tests++;
    if (prog_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_we_n1: got %b expected 0", prog_we);
    end
    @(negedge clk);
    n_tests++;
    if ({prog_we, prog_bank, prog_addr, prog_mask, prog_data} !== {1'b1, 2'd0, 22'd0, 2'b10, 16'h1111}) begin
      n_fail++;
      $display("FAIL basic_first_write: got %h expected %h", {prog_we, prog_bank, prog_addr, prog_mask, prog_data},
               {1'b1, 2'd0, 22'd0, 2'b10, 16'h1111});
    end
    send_byte(25'h1, 8'h22);
    wait_got(2, 50, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: got %0d writes expected 2", got_q.size());
    end else begin
      n_tests++;
      if (got_q[1] !== {2'd0, 22'd0, 16'h2222, 2'b01}) begin
        n_fail++;
        $display("FAIL basic_second_write: got %h expected %h", got_q[1], {2'd0, 22'd0, 16'h2222, 2'b01});
      end
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL basic_model[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_bank2();
    bit ok;
    logic [7:0] d;
    clear_queues();
    d = 8'($urandom);
    send_byte(25'h20_0005, d);
    wait_got(1, 50, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bank2_timeout: got %0d writes expected 1", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== {2'd2, 22'd2, d, d, 2'b01}) begin
        n_fail++;
        $display("FAIL bank2_write: got %h expected %h", got_q[0], {2'd2, 22'd2, d, d, 2'b01});
      end
    end
  endtask

  task automatic test_prom();
    int we0;
    clear_queues();
    we0 = we_cycles;
    @(negedge clk);
    ioctl_addr = 25'h40_0003; ioctl_data = 8'hA5; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    n_tests++;
    if ({prom_we, prom_addr, prom_data} !== {1'b1, 25'd3, 8'hA5}) begin
      n_fail++;
      $display("FAIL prom_strobe: got %h expected %h", {prom_we, prom_addr, prom_data}, {1'b1, 25'd3, 8'hA5});
    end
    @(negedge clk);
    n_tests++;
    if (prom_we !== 1'b0) begin
      n_fail++;
      $display("FAIL prom_one_cycle: got %b expected 0", prom_we);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (we_cycles != we0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL prom_no_sdram: got %0d prog_we cycles expected 0", we_cycles - we0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [24:0] a;
    logic [7:0]  d;
    clear_queues();
    rdy_mode = 0;
    prog_rdy = 1'b0;
    start_download();
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_cleared: got %b expected 0", overflow);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 25'(BA1 + 32'(i));
      d = 8'($urandom);
      ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
      if (i < 8) exp_q.push_back(model_sdram(a, d));
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({overflow, prog_we} !== 2'b11 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf/we %b writes %0d expected 11 and 0", {overflow, prog_we}, got_q.size());
    end
    rdy_mode = 1;
    wait_got(8, 300, ok);
    repeat (30) @(negedge clk);
    rdy_mode = 0;
    prog_rdy = 1'b0;
    n_tests++;
    if (!ok || got_q.size() != 8) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d writes expected 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL overflow_model[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_drain();
    clear_queues();
    rdy_mode = 0;
    prog_rdy = 1'b0;
    start_download();
    for (int i = 0; i < 5; i++) send_byte(25'(BA3 + 32'(2 * i + 1)), 8'($urandom));
    @(negedge clk);
    downloading = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({dwnld_busy, prog_we} !== 2'b11) begin
      n_fail++;
      $display("FAIL drain_busy_held: got %b expected 11", {dwnld_busy, prog_we});
    end
    for (int k = 0; k < 5; k++) begin
      prog_rdy = 1'b1;
      @(negedge clk);
      prog_rdy = 1'b0;
      n_tests++;
      if (dwnld_busy !== (k < 4)) begin
        n_fail++;
        $display("FAIL drain_busy_after_rdy%0d: got %b expected %b", k + 1, dwnld_busy, (k < 4));
      end
      @(negedge clk);
    end
    n_tests++;
    if (got_q.size() != 5) begin
      n_fail++;
      $display("FAIL drain_count: got %0d writes expected 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL drain_model[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int we0;
    clear_queues();
    rdy_mode = 0;
    prog_rdy = 1'b0;
    start_download();
    send_byte(25'h00_0100, 8'h3C);
    send_byte(25'h10_0200, 8'h4D);
    repeat (2) @(negedge clk);
    n_tests++;
    if (prog_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pending: got %b expected 1", prog_we);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({prog_we, dwnld_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 00", {prog_we, dwnld_busy});
    end
    @(negedge clk);
    downloading = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    we0 = we_cycles;
    rdy_mode = 1;
    repeat (30) @(negedge clk);
    rdy_mode = 0;
    prog_rdy = 1'b0;
    n_tests++;
    if (we_cycles != we0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_retry: got %0d prog_we cycles expected 0", we_cycles - we0);
    end
  endtask

  task automatic test_random();
    bit ok;
    int r;
    logic [24:0] a;
    clear_queues();
    start_download();
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: a = 25'($urandom_range(0, 32'h0F_FFFF));
        1: a = 25'(BA1 + $urandom_range(0, 32'h0F_FFFF));
        2: a = 25'(BA2 + $urandom_range(0, 32'h0F_FFFF));
        3: a = 25'(BA3 + $urandom_range(0, 32'h0F_FFFF));
        4: a = 25'(PROM + $urandom_range(0, 32'hFFFF));
        default: a = 25'($urandom);
      endcase
      send_byte(a, 8'($urandom));
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    downloading = 1'b0;
    wait_got(exp_q.size(), 500, ok);
    for (int i = 0; i < 200 && dwnld_busy; i++) @(negedge clk);
    rdy_mode = 0;
    prog_rdy = 1'b0;
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d writes expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_sdram[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (prom_got_q.size() != prom_exp_q.size()) begin
      n_fail++;
      $display("FAIL random_prom_count: got %0d expected %0d", prom_got_q.size(), prom_exp_q.size());
    end else begin
      for (int i = 0; i < prom_exp_q.size(); i++) begin
        n_tests++;
        if (prom_got_q[i] !== prom_exp_q[i]) begin
          n_fail++;
          $display("FAIL random_prom[%0d]: got %h expected %h", i, prom_got_q[i], prom_exp_q[i]);
        end
      end
    end
    n_tests++;
    if ({dwnld_busy, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL random_end_flags: got busy/ovf %b expected 00", {dwnld_busy, overflow});
    end
  endtask

  task automatic test_ignore();
    int g0, p0, w0;
    g0 = got_q.size();
    p0 = prom_got_q.size();
    w0 = we_cycles;
    rdy_mode = 1;
    send_byte(25'h00_0010, 8'h5A);
    send_byte(25'h40_0010, 8'hC3);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    prog_rdy = 1'b0;
    n_tests++;
    if (got_q.size() != g0 || prom_got_q.size() != p0 || we_cycles != w0) begin
      n_fail++;
      $display("FAIL ignore_when_idle: got %0d/%0d/%0d new events expected 0/0/0",
               got_q.size() - g0, prom_got_q.size() - p0, we_cycles - w0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_bank2();
    test_prom();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_random();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
